ysyx_bus_arb: RTL

//  Two-master to one-slave memory bus arbiter. IFU (read-only) and LSU (read/write) share one memory port.

---
 rtl/ysyx_bus_arb.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_bus_arb.sv
// rtl/ysyx_bus_arb.sv - two-master (IFU/LSU) to one-slave memory bus arbiter
// Optional YSYX_BUS_ARB_RR_EN: round-robin between IFU and LSU instead of fixed LSU priority.
module ysyx_bus_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rvalid,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rvalid,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wvalid,
    output logic                lsu_bvalid,
    output logic [ADDR_W-1:0]   mem_araddr,
    output logic                mem_arvalid,
    input  logic                mem_arready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rvalid,
    output logic [ADDR_W-1:0]   mem_awaddr,
    output logic                mem_awvalid,
    input  logic                mem_awready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_wvalid,
    input  logic                mem_wready,
    input  logic                mem_bvalid,
    output logic                busy
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                mem_arvalid_q, mem_arvalid_d;
    logic                mem_awvalid_q, mem_awvalid_d;
    logic                mem_wvalid_q, mem_wvalid_d;
    logic                lsu_req;
    logic                grant_lsu;
    logic                rd_done;

    assign lsu_req = lsu_wvalid | lsu_arvalid;

`ifdef YSYX_BUS_ARB_RR_EN
    logic last_owner_q, last_owner_d;
    // LSU yields only when the IFU is waiting and the LSU had the previous grant.
    assign grant_lsu = lsu_req && !(ifu_arvalid && (last_owner_q == OWN_LSU));
`else
    assign grant_lsu = lsu_req;
`endif

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        mem_arvalid_d = mem_arvalid_q;
        mem_awvalid_d = mem_awvalid_q;
        mem_wvalid_d  = mem_wvalid_q;
        case (state_q)
            IDLE: begin
                if (grant_lsu && lsu_wvalid) begin
                    state_d       = WR_REQ;
                    owner_d       = OWN_LSU;
                    addr_d        = lsu_awaddr;
                    wdata_d       = lsu_wdata;
                    wstrb_d       = lsu_wstrb;
                    mem_awvalid_d = 1'b1;
                    mem_wvalid_d  = 1'b1;
                end else if (grant_lsu) begin
                    state_d       = RD_ADDR;
                    owner_d       = OWN_LSU;
                    addr_d        = lsu_araddr;
                    mem_arvalid_d = 1'b1;
                end else if (ifu_arvalid) begin
                    state_d       = RD_ADDR;
                    owner_d       = OWN_IFU;
                    addr_d        = ifu_araddr;
                    mem_arvalid_d = 1'b1;
                end
            end
            RD_ADDR: begin
                if (mem_arready) begin
                    mem_arvalid_d = 1'b0;
                    state_d       = mem_rvalid ? IDLE : RD_DATA;
                end
            end
            RD_DATA: begin
                if (mem_rvalid) state_d = IDLE;
            end
            WR_REQ: begin
                // Address and data channels retire independently.
                mem_awvalid_d = mem_awvalid_q & ~mem_awready;
                mem_wvalid_d  = mem_wvalid_q & ~mem_wready;
                if (!mem_awvalid_d && !mem_wvalid_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (mem_bvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef YSYX_BUS_ARB_RR_EN
    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == IDLE && state_d != IDLE) last_owner_d = owner_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_IFU;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            mem_arvalid_q <= 1'b0;
            mem_awvalid_q <= 1'b0;
            mem_wvalid_q  <= 1'b0;
`ifdef YSYX_BUS_ARB_RR_EN
            last_owner_q  <= OWN_LSU;
`endif
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            mem_arvalid_q <= mem_arvalid_d;
            mem_awvalid_q <= mem_awvalid_d;
            mem_wvalid_q  <= mem_wvalid_d;
`ifdef YSYX_BUS_ARB_RR_EN
            last_owner_q  <= last_owner_d;
`endif
        end
    end

    // A zero-wait slave may return data in the same cycle it accepts the address.
    assign rd_done    = mem_rvalid && ((state_q == RD_DATA) || (state_q == RD_ADDR && mem_arready));
    assign ifu_rvalid = rd_done && (owner_q == OWN_IFU);
    assign lsu_rvalid = rd_done && (owner_q == OWN_LSU);
    assign ifu_rdata  = ifu_rvalid ? mem_rdata : '0;
    assign lsu_rdata  = lsu_rvalid ? mem_rdata : '0;
    assign lsu_bvalid = (state_q == WR_RESP) && mem_bvalid;

    assign mem_araddr  = addr_q;
    assign mem_arvalid = mem_arvalid_q;
    assign mem_awaddr  = addr_q;
    assign mem_awvalid = mem_awvalid_q;
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = wstrb_q;
    assign mem_wvalid  = mem_wvalid_q;
    assign busy        = (state_q != IDLE);

endmodule
